// File: rtl/vend_dispense_ctrl.sv
// Vending dispense controller: drives one slot motor, waits for the product drop,
// then ejects change (or a refund on drop timeout) as timed coin pulses.
module vend_dispense_ctrl #(
  parameter int unsigned MOTOR_CYC    = 8,
  parameter int unsigned TIMEOUT_CYC  = 64,
  parameter int unsigned COIN_ON_CYC  = 4,
  parameter int unsigned COIN_OFF_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vend_valid,
  output logic       vend_ready,
  input  logic [1:0] vend_sel,
  input  logic [3:0] vend_change,
  input  logic [3:0] vend_refund,
  input  logic       drop_sense,
  output logic [3:0] motor_en,
  output logic       coin_out,
  output logic [3:0] coins_left,
  output logic       busy,
  output logic       fault,
  output logic       done
);

  typedef enum logic [2:0] {
    StIdle, StMotor, StWaitDrop, StCoinOn, StCoinOff, StFinish
  } state_e;

  // Counters run from N-1 down to 0, so each state lasts exactly N cycles.
  localparam logic [7:0] MotorLoad   = 8'(MOTOR_CYC - 1);
  localparam logic [7:0] TimeoutLoad = 8'(TIMEOUT_CYC - 1);
  localparam logic [7:0] CoinOnLoad  = 8'(COIN_ON_CYC - 1);
  localparam logic [7:0] CoinOffLoad = 8'(COIN_OFF_CYC - 1);

  state_e     state_q;
  logic [1:0] sel_q;
  logic [3:0] change_q;
  logic [3:0] refund_q;
  logic [3:0] coins_q;
  logic [7:0] cnt_q;
  logic [1:0] sync_q;
  logic       drop_q;
  logic       fault_q;

  logic       drop_hit;
  logic [3:0] pay;

  // Sticky flag plus the live synchronized level, so a drop arriving in
  // WAIT_DROP is acted on without an extra cycle.
  assign drop_hit = drop_q | sync_q[1];
  assign pay      = drop_hit ? change_q : refund_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sel_q    <= 2'd0;
      change_q <= 4'd0;
      refund_q <= 4'd0;
      coins_q  <= 4'd0;
      cnt_q    <= 8'd0;
      sync_q   <= 2'b00;
      drop_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], drop_sense};
      if ((state_q == StMotor || state_q == StWaitDrop) && sync_q[1]) begin
        drop_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (vend_valid) begin
            sel_q    <= vend_sel;
            change_q <= vend_change;
            refund_q <= vend_refund;
            fault_q  <= 1'b0;
            drop_q   <= 1'b0;
            cnt_q    <= MotorLoad;
            state_q  <= StMotor;
          end
        end
        StMotor: begin
          if (cnt_q == 8'd0) begin
            cnt_q   <= TimeoutLoad;
            state_q <= StWaitDrop;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StWaitDrop: begin
          if (drop_hit || cnt_q == 8'd0) begin
            coins_q <= pay;
            if (!drop_hit) fault_q <= 1'b1;
            cnt_q   <= CoinOnLoad;
            state_q <= (pay != 4'd0) ? StCoinOn : StFinish;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StCoinOn: begin
          if (cnt_q == 8'd0) begin
            if (coins_q != 4'd0) coins_q <= coins_q - 4'd1;
            cnt_q   <= CoinOffLoad;
            state_q <= StCoinOff;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StCoinOff: begin
          if (cnt_q == 8'd0) begin
            if (coins_q != 4'd0) begin
              cnt_q   <= CoinOnLoad;
              state_q <= StCoinOn;
            end else begin
              state_q <= StFinish;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StFinish: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  assign vend_ready = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign motor_en   = (state_q == StMotor) ? (4'b0001 << sel_q) : 4'b0000;
  assign coin_out   = (state_q == StCoinOn);
  assign done       = (state_q == StFinish);
  assign coins_left = coins_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed bench for vend_dispense_ctrl: observes each vend cycle by cycle and
// compares timing and outputs against hand-computed expectations.
module tb_vend_dispense_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vend_valid;
  logic       vend_ready;
  logic [1:0] vend_sel;
  logic [3:0] vend_change;
  logic [3:0] vend_refund;
  logic       drop_sense;
  logic [3:0] motor_en;
  logic       coin_out;
  logic [3:0] coins_left;
  logic       busy;
  logic       fault;
  logic       done;

  vend_dispense_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vend_valid (vend_valid),
    .vend_ready (vend_ready),
    .vend_sel   (vend_sel),
    .vend_change(vend_change),
    .vend_refund(vend_refund),
    .drop_sense (drop_sense),
    .motor_en   (motor_en),
    .coin_out   (coin_out),
    .coins_left (coins_left),
    .busy       (busy),
    .fault      (fault),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-vend observations
  int         motor_cyc, motor_bad, gap, pulses, hi_bad, lo_bad, done_cnt, cl_bad;
  logic       seen_done, fault_at_done, fault_in_motor, idle_after;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drop_mode: 0 never, 1 raised drop_at cycles after MOTOR ends, 2 one-cycle pulse in MOTOR
  task automatic run_vend(input logic [1:0] sel, input logic [3:0] chg, input logic [3:0] rfd,
                          input int drop_mode, input int drop_at, input logic [3:0] total);
    int   post, run;
    logic in_gap, prev_coin;
    logic [3:0] exp_motor;
    exp_motor = 4'b0001 << sel;
    motor_cyc = 0; motor_bad = 0; gap = 0; pulses = 0; hi_bad = 0; lo_bad = 0;
    done_cnt = 0; cl_bad = 0; seen_done = 1'b0; fault_at_done = 1'b0;
    fault_in_motor = 1'b1; idle_after = 1'b0;
    post = 0; run = 0; in_gap = 1'b1; prev_coin = 1'b0;
    @(negedge clk);
    vend_sel = sel; vend_change = chg; vend_refund = rfd; vend_valid = 1'b1;
    @(negedge clk);
    vend_valid = 1'b0;
    fault_in_motor = fault;
    for (int c = 0; c < 400 && !seen_done; c++) begin
      if (c > 0) @(negedge clk);
      if (motor_en != 4'b0000) begin
        motor_cyc++;
        if (motor_en != exp_motor) motor_bad++;
        if (drop_mode == 2) drop_sense = (motor_cyc == 3);
      end else if (motor_cyc > 0) begin
        if (drop_mode == 2) drop_sense = 1'b0;
        if (drop_mode == 1 && post == drop_at) drop_sense = 1'b1;
        post++;
        if (coin_out || done) in_gap = 1'b0;
        if (in_gap) gap++;
        if (coin_out && !prev_coin) begin
          if (pulses > 0 && run != 4) lo_bad++;
          if (coins_left != total - 4'(pulses)) cl_bad++;
          pulses++;
          run = 0;
        end else if (!coin_out && prev_coin) begin
          if (run != 4) hi_bad++;
          run = 0;
        end
        if (done) begin
          done_cnt++;
          seen_done = 1'b1;
          fault_at_done = fault;
          if (pulses > 0 && run != 4) lo_bad++;
        end
        run++;
        prev_coin = coin_out;
      end
    end
    check_eq("vend_completes", 32'(seen_done), 32'd1);
    @(negedge clk);
    if (done) done_cnt++;
    idle_after = !busy && vend_ready && !done;
    drop_sense = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int bad;
    rst_n = 1'b0; vend_valid = 1'b0; vend_sel = 2'd0; vend_change = 4'd0;
    vend_refund = 4'd0; drop_sense = 1'b0;
    #12;
    check_eq("rst_outputs", {vend_ready, busy, fault, done, coin_out, motor_en, coins_left},
             {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'd0});
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Normal vend, no change; drop 10 cycles after MOTOR ends, seen 2 cycles later
    run_vend(2'd2, 4'd0, 4'd7, 1, 10, 4'd0);
    check_eq("norm_motor_cycles", 32'(motor_cyc), 32'd8);
    check_eq("norm_motor_value", 32'(motor_bad), 32'd0);
    check_eq("norm_wait_len", 32'(gap), 32'd13);
    check_eq("norm_pulses", 32'(pulses), 32'd0);
    check_eq("norm_done_once", 32'(done_cnt), 32'd1);
    check_eq("norm_fault", 32'(fault_at_done), 32'd0);
    check_eq("norm_idle_after", 32'(idle_after), 32'd1);

    // Change of three coins
    run_vend(2'd1, 4'd3, 4'd9, 1, 0, 4'd3);
    check_eq("chg_motor_value", 32'(motor_bad), 32'd0);
    check_eq("chg_wait_len", 32'(gap), 32'd3);
    check_eq("chg_pulses", 32'(pulses), 32'd3);
    check_eq("chg_hi_width", 32'(hi_bad), 32'd0);
    check_eq("chg_lo_width", 32'(lo_bad), 32'd0);
    check_eq("chg_coins_seq", 32'(cl_bad), 32'd0);
    check_eq("chg_coins_end", 32'(coins_left), 32'd0);
    check_eq("chg_fault", 32'(fault_at_done), 32'd0);

    // Timeout: refund of five instead of change of two
    run_vend(2'd0, 4'd2, 4'd5, 0, 0, 4'd5);
    check_eq("to_wait_len", 32'(gap), 32'd64);
    check_eq("to_pulses", 32'(pulses), 32'd5);
    check_eq("to_coins_seq", 32'(cl_bad), 32'd0);
    check_eq("to_widths", 32'(hi_bad + lo_bad), 32'd0);
    check_eq("to_fault_done", 32'(fault_at_done), 32'd1);
    check_eq("to_done_once", 32'(done_cnt), 32'd1);
    check_eq("to_fault_idle", {31'd0, fault}, 32'd1);

    // Early drop during MOTOR; accept also clears the held fault
    run_vend(2'd3, 4'd0, 4'd0, 2, 0, 4'd0);
    check_eq("early_fault_clr", 32'(fault_in_motor), 32'd0);
    check_eq("early_motor_cycles", 32'(motor_cyc), 32'd8);
    check_eq("early_wait_len", 32'(gap), 32'd1);
    check_eq("early_done_once", 32'(done_cnt), 32'd1);

    // Reset mid-COIN_ON, with vend_valid ignored while busy
    @(negedge clk);
    vend_sel = 2'd0; vend_change = 4'd2; vend_refund = 4'd0; vend_valid = 1'b1;
    @(negedge clk);
    vend_sel = 2'd3; vend_change = 4'd9;
    bad = 0;
    repeat (4) begin
      if (motor_en != 4'b0001 || vend_ready) bad++;
      @(negedge clk);
    end
    vend_valid = 1'b0;
    drop_sense = 1'b1;
    check_eq("busy_valid_ignored", 32'(bad), 32'd0);
    for (int c = 0; c < 200 && !coin_out; c++) @(negedge clk);
    check_eq("rstmid_coin_on", {31'd0, coin_out}, 32'd1);
    check_eq("rstmid_coins", 32'(coins_left), 32'd2);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rstmid_outputs", {vend_ready, busy, fault, done, coin_out, motor_en, coins_left},
             {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'd0});
    drop_sense = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy || coin_out || motor_en != 4'b0000 || !vend_ready) bad++;
    end
    check_eq("rstmid_no_resume", 32'(bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_dispense_ctrl.md
VEND_DISPENSE_CTRL -- requirements
Module: vend_dispense_ctrl

Interface
REQ-001 SHALL have parameter MOTOR_CYC, default 8, meaning motor drive duration in cycles (legal 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 64, meaning maximum cycles waiting for the drop sensor (legal 1..255).
REQ-003 SHALL have parameter COIN_ON_CYC, default 4, meaning coin ejector high time in cycles (legal 1..255).
REQ-004 SHALL have parameter COIN_OFF_CYC, default 4, meaning the gap between coin pulses in cycles (legal 1..255).
REQ-005 SHALL have port clk  in  1  the single clock, with all state rising-edge triggered.
REQ-006 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port vend_valid  in  1  vend command request.
REQ-008 SHALL have port vend_ready  out  1  command accepted when high with vend_valid.
REQ-009 SHALL have port vend_sel  in  2  product slot 0..3.
REQ-010 SHALL have port vend_change  in  4  change coins owed on successful vend.
REQ-011 SHALL have port vend_refund  in  4  coins owed if the product fails to drop.
REQ-012 SHALL have port drop_sense  in  1  asynchronous product-drop sensor, active high.
REQ-013 SHALL have port motor_en  out  4  one-hot slot motor drive.
REQ-014 SHALL have port coin_out  out  1  coin ejector drive.
REQ-015 SHALL have port coins_left  out  4  coins still to eject.
REQ-016 SHALL have port busy  out  1  high in every state except IDLE.
REQ-017 SHALL have port fault  out  1  drop timeout occurred; held until the next accepted command.
REQ-018 SHALL have port done  out  1  one-cycle completion pulse.

Function
REQ-019 SHALL implement a Moore FSM with states IDLE, MOTOR, WAIT_DROP, COIN_ON, COIN_OFF, FINISH; all outputs SHALL be registered or decoded from state only.
REQ-020 SHALL assert vend_ready only in IDLE; vend_valid in any other state SHALL be ignored without side effects.
REQ-021 SHALL, on a clock edge with vend_valid and vend_ready high, capture vend_sel, vend_change and vend_refund, clear fault, load the 8-bit cycle counter and enter MOTOR.
REQ-022 SHALL drive motor_en[sel]=1 with the other bits 0 for exactly MOTOR_CYC cycles in MOTOR, then enter WAIT_DROP; motor_en SHALL be 0 in all other states.
REQ-023 SHALL pass drop_sense through a 2-flop synchronizer (2-cycle latency) and SHALL treat a high synchronized level seen in MOTOR or WAIT_DROP as a drop, latched in a sticky flag cleared on accept.
REQ-024 SHALL leave WAIT_DROP in its first cycle if the drop flag is set, loading coins_left with the captured change.
REQ-025 SHALL, if no drop is seen within TIMEOUT_CYC cycles of WAIT_DROP, set fault and load coins_left with the captured refund instead.
REQ-026 SHALL go from WAIT_DROP to COIN_ON if the loaded count is non-zero, otherwise to FINISH.
REQ-027 SHALL drive coin_out=1 for exactly COIN_ON_CYC cycles in COIN_ON, then decrement coins_left by 1 and enter COIN_OFF.
REQ-028 SHALL hold coin_out=0 for exactly COIN_OFF_CYC cycles in COIN_OFF, then return to COIN_ON if coins_left is non-zero, otherwise go to FINISH.
REQ-029 SHALL assert done for exactly one cycle in FINISH, then return to IDLE; fault SHALL remain visible through FINISH and IDLE.
REQ-030 SHALL never underflow coins_left; a value of 0 SHALL never enter COIN_ON.

Reset
REQ-031 SHALL, while rst_n is low, immediately force state IDLE, motor_en=0, coin_out=0, coins_left=0, busy=0, fault=0, done=0, clear the synchronizer, drop flag and counters, and set vend_ready=1.
REQ-032 SHALL, when reset is asserted mid-operation, abandon the operation with no resumption after release.

Verification
REQ-033 SHALL cover reset: pulse rst_n low -> all outputs 0 except vend_ready=1.
REQ-034 SHALL cover a normal vend: sel=2, change=0, drop asserted 10 cycles after MOTOR ends -> motor_en=4'b0100 for 8 cycles, no coin pulses, done pulse, fault=0.
REQ-035 SHALL cover change ejection: sel=1, change=3, drop asserted in time -> 3 coin_out pulses of 4 cycles high and 4 low, coins_left 3->2->1->0, then done.
REQ-036 SHALL cover a timeout: drop never asserted, change=2, refund=5 -> fault=1 after 64 WAIT_DROP cycles, 5 coin pulses, done, fault held in IDLE until the next accept.
REQ-037 SHALL cover an early drop: drop_sense pulsed during MOTOR -> WAIT_DROP lasts exactly 1 cycle.
REQ-038 SHALL cover reset mid-COIN_ON: rst_n low -> coin_out=0 immediately and IDLE after release; vend_valid during busy is ignored.
